// File: rtl/beat_detector.sv
// beat_detector: R-peak detector for a unsigned ECG sample stream.
// A threshold with hysteresis opens and closes a peak window. A refractory
// period follows each beat. For every beat the block reports the peak
// amplitude and the R-R interval, counted in accepted samples.
module beat_detector #(
   parameter int unsigned NBIT    = 16,
   parameter int unsigned CW      = 12,
   parameter int unsigned THRESH  = 1000,
   parameter int unsigned HYST    = 100,
   parameter int unsigned REFRACT = 50
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NBIT-1:0] sample_in,
   input  logic            sample_valid,
   input  logic            stream_over,
   output logic            beat,
   output logic [NBIT-1:0] peak_amp,
   output logic [CW-1:0]   rr_count,
   output logic            rr_valid,
   output logic            done
);

   localparam int unsigned   RW      = $clog2(REFRACT + 1);
   localparam logic [NBIT-1:0] TH_HI = NBIT'(THRESH);
   localparam logic [NBIT-1:0] TH_LO = NBIT'(THRESH - HYST);
   localparam logic [CW-1:0] IVL_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {S_SEARCH, S_PEAK, S_REFRACT, S_DONE} state_t;

   state_t          r_state,       w_state_n;
   logic [CW-1:0]   r_ivl,         w_ivl_n;
   logic [NBIT-1:0] r_max,         w_max_n;
   logic [CW-1:0]   r_ivl_at_max,  w_ivl_at_max_n;
   logic            r_have_prev,   w_have_prev_n;
   logic [RW-1:0]   r_rcnt,        w_rcnt_n;
   logic            w_beat_n;
   logic [NBIT-1:0] w_peak_amp_n;
   logic [CW-1:0]   w_rr_count_n;
   logic            w_rr_valid_n;
   logic            w_done_n;

   logic            w_accept;
   logic [CW-1:0]   w_ivl_inc;
   logic [CW-1:0]   w_ivl_since;

   assign w_accept    = sample_valid & ~stream_over;
   assign w_ivl_inc   = (r_ivl == IVL_MAX) ? r_ivl : r_ivl + CW'(1);
   // Samples since the peak, including the current one; never exceeds IVL_MAX
   // because ivl_at_max is always at least 1 when a peak is open.
   assign w_ivl_since = CW'(({1'b0, r_ivl} + (CW+1)'(1)) - {1'b0, r_ivl_at_max});

   // Next-state and next-output logic for the detector.
   always_comb begin
      w_state_n      = r_state;
      w_ivl_n        = r_ivl;
      w_max_n        = r_max;
      w_ivl_at_max_n = r_ivl_at_max;
      w_have_prev_n  = r_have_prev;
      w_rcnt_n       = r_rcnt;
      w_beat_n       = 1'b0;
      w_peak_amp_n   = peak_amp;
      w_rr_count_n   = rr_count;
      w_rr_valid_n   = rr_valid;
      w_done_n       = done;

      if (stream_over) begin
         w_state_n = S_DONE;
         w_done_n  = 1'b1;
      end else if (w_accept) begin
         unique case (r_state)
            S_SEARCH: begin
               w_ivl_n = w_ivl_inc;
               if (sample_in >= TH_HI) begin
                  w_state_n      = S_PEAK;
                  w_max_n        = sample_in;
                  w_ivl_at_max_n = w_ivl_inc;
               end
            end
            S_PEAK: begin
               w_ivl_n = w_ivl_inc;
               if (sample_in > r_max) begin
                  w_max_n        = sample_in;
                  w_ivl_at_max_n = w_ivl_inc;
               end else if (sample_in < TH_LO) begin
                  w_beat_n      = 1'b1;
                  w_peak_amp_n  = r_max;
                  w_rr_count_n  = r_ivl_at_max;
                  w_rr_valid_n  = r_have_prev & (r_ivl_at_max != IVL_MAX);
                  w_ivl_n       = w_ivl_since;
                  w_have_prev_n = 1'b1;
                  w_rcnt_n      = RW'(REFRACT);
                  w_state_n     = S_REFRACT;
               end
            end
            S_REFRACT: begin
               w_ivl_n  = w_ivl_inc;
               w_rcnt_n = r_rcnt - RW'(1);
               if (r_rcnt == RW'(1)) begin
                  w_state_n = S_SEARCH;
               end
            end
            S_DONE: begin
               w_state_n = S_DONE;
            end
            default: begin
               w_state_n = S_SEARCH;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_SEARCH;
         r_ivl        <= '0;
         r_max        <= '0;
         r_ivl_at_max <= '0;
         r_have_prev  <= 1'b0;
         r_rcnt       <= '0;
         beat         <= 1'b0;
         peak_amp     <= '0;
         rr_count     <= '0;
         rr_valid     <= 1'b0;
         done         <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_ivl        <= w_ivl_n;
         r_max        <= w_max_n;
         r_ivl_at_max <= w_ivl_at_max_n;
         r_have_prev  <= w_have_prev_n;
         r_rcnt       <= w_rcnt_n;
         beat         <= w_beat_n;
         peak_amp     <= w_peak_amp_n;
         rr_count     <= w_rr_count_n;
         rr_valid     <= w_rr_valid_n;
         done         <= w_done_n;
      end
   end

endmodule

// File: tb/tb_beat_detector.sv
// tb_beat_detector: directed and randomized checks of beat_detector
// against a per-sample behavioural model kept in the bench.
module tb_beat_detector;

   localparam int NBIT    = 16;
   localparam int CW      = 12;
   localparam int THRESH  = 1000;
   localparam int HYST    = 100;
   localparam int REFRACT = 4;
   localparam int SATV    = (1 << CW) - 1;

   logic            clk;
   logic            rst;
   logic [NBIT-1:0] sample_in;
   logic            sample_valid;
   logic            stream_over;
   logic            beat;
   logic [NBIT-1:0] peak_amp;
   logic [CW-1:0]   rr_count;
   logic            rr_valid;
   logic            done;

   int n_vec;
   int n_err;
   int n_beats;

   beat_detector #(
      .NBIT(NBIT), .CW(CW), .THRESH(THRESH), .HYST(HYST), .REFRACT(REFRACT)
   ) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .stream_over(stream_over), .beat(beat), .peak_amp(peak_amp),
      .rr_count(rr_count), .rr_valid(rr_valid), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: mode 0 hunting, 1 inside peak, 2 refractory, 3 finished.
   int m_mode, m_ivl, m_max, m_at_max, m_prev, m_left;
   int e_beat, e_amp, e_rr, e_rrv, e_done;

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_next(input int v);
      return (v + 1 > SATV) ? SATV : v + 1;
   endfunction

   task automatic model_clear();
      m_mode = 0; m_ivl = 0; m_max = 0; m_at_max = 0; m_prev = 0; m_left = 0;
      e_beat = 0; e_amp = 0; e_rr = 0; e_rrv = 0; e_done = 0;
   endtask

   task automatic model_sample(input int s, input bit v, input bit o);
      e_beat = 0;
      if (o) begin
         m_mode = 3;
         e_done = 1;
      end else if (v && m_mode != 3) begin
         int nx;
         nx = sat_next(m_ivl);
         if (m_mode == 0) begin
            m_ivl = nx;
            if (s >= THRESH) begin
               m_mode = 1; m_max = s; m_at_max = nx;
            end
         end else if (m_mode == 1) begin
            if (s > m_max) begin
               m_max = s; m_at_max = nx; m_ivl = nx;
            end else if (s < THRESH - HYST) begin
               e_beat = 1;
               e_amp  = m_max;
               e_rr   = m_at_max;
               e_rrv  = (m_prev != 0 && m_at_max != SATV) ? 1 : 0;
               m_ivl  = m_ivl + 1 - m_at_max;
               m_prev = 1;
               m_left = REFRACT;
               m_mode = 2;
            end else begin
               m_ivl = nx;
            end
         end else begin
            m_ivl = nx;
            m_left--;
            if (m_left == 0) m_mode = 0;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("beat", 32'(beat), e_beat);
      check_val("peak_amp", 32'(peak_amp), e_amp);
      check_val("rr_count", 32'(rr_count), e_rr);
      check_val("rr_valid", 32'(rr_valid), e_rrv);
      check_val("done", 32'(done), e_done);
      if (beat === 1'b1) n_beats++;
   endtask

   task automatic step(input int s, input bit v, input bit o);
      sample_in    = NBIT'(s);
      sample_valid = v;
      stream_over  = o;
      @(posedge clk);
      model_sample(s, v, o);
      #1;
      check_outputs();
   endtask

   task automatic feed(input int s, input int n);
      for (int i = 0; i < n; i++) step(s, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_in = NBIT'($urandom_range(0, 2000));
      sample_valid = 1'b1;
      stream_over  = 1'b0;
      @(posedge clk);
      model_clear();
      #1;
      check_outputs();
      rst = 1'b0;
      n_beats = 0;
   endtask

   task automatic pulse100();
      feed(500, 10); feed(1200, 1); feed(1500, 1); feed(1300, 1); feed(800, 1);
      feed(500, 86);
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_beats = 0;
      rst = 1'b1; sample_in = '0; sample_valid = 1'b0; stream_over = 1'b0;
      model_clear();

      // Reset state.
      do_reset();

      // Single pulse.
      feed(500, 10); feed(1200, 1); feed(1500, 1); feed(1300, 1); feed(800, 1);
      feed(500, 20);
      check_val("t1_beats", n_beats, 1);
      check_val("t1_amp", 32'(peak_amp), 1500);
      check_val("t1_rrv", 32'(rr_valid), 0);

      // Periodic pulses give the R-R interval.
      do_reset();
      pulse100(); pulse100();
      check_val("t2_beats", n_beats, 2);
      check_val("t2_rr", 32'(rr_count), 100);
      check_val("t2_rrv", 32'(rr_valid), 1);

      // Hysteresis band keeps the peak open.
      do_reset();
      feed(500, 1); feed(1200, 1); feed(950, 1); feed(1100, 1); feed(950, 1);
      feed(850, 1); feed(500, 10);
      check_val("t3_beats", n_beats, 1);
      check_val("t3_amp", 32'(peak_amp), 1200);

      // Refractory window.
      do_reset();
      feed(1200, 1); feed(850, 1); feed(1300, 4); feed(1300, 1); feed(850, 1);
      check_val("t4_beats", n_beats, 2);
      check_val("t4_rr", 32'(rr_count), 6);
      check_val("t4_amp", 32'(peak_amp), 1300);

      // Interval counter saturation.
      do_reset();
      feed(1200, 1); feed(850, 1); feed(500, 5000); feed(1200, 1); feed(850, 1);
      check_val("t5_beats", n_beats, 2);
      check_val("t5_rr", 32'(rr_count), SATV);
      check_val("t5_rrv", 32'(rr_valid), 0);

      // stream_over inside a peak discards it.
      do_reset();
      feed(500, 1); feed(1200, 1); step(1300, 1'b1, 1'b1);
      check_val("t6_done", 32'(done), 1);
      step(850, 1'b1, 1'b0); feed(850, 2);
      check_val("t6_beats", n_beats, 0);

      // Reset inside a peak clears everything.
      do_reset();
      feed(1200, 1); feed(850, 1); feed(500, 5); feed(1200, 1); feed(1300, 1);
      do_reset();
      check_val("t6b_amp", 32'(peak_amp), 0);
      feed(850, 3);
      check_val("t6b_beats", n_beats, 0);

      // Randomized segments with gaps, rare stream_over and rare resets.
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         for (int c = 0; c < 2500; c++) begin
            int r, s;
            bit v, o;
            r = int'($urandom_range(0, 9));
            if (r < 5)      s = int'($urandom_range(0, 899));
            else if (r < 7) s = int'($urandom_range(900, 999));
            else            s = int'($urandom_range(1000, 2000));
            v = ($urandom_range(0, 9) < 8);
            o = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 1999) == 0) do_reset();
            else step(s, v, o);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
